// File: rtl/stream_data_transmitter.sv
// Packet framer: header, memory-sourced payload and XOR trailer, then a minimum idle gap.
// The header reaches TxData two cycles after Start is sampled. Payload follows back-to-back and there is no backpressure.
module stream_data_transmitter #(
    parameter logic [7:0]  KStart   = 8'h5C,
    parameter logic [7:0]  KIdle    = 8'hBC,
    parameter int unsigned GapWords = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [15:0] SourceAddress,
    input  logic [11:0] PacketDest,
    input  logic [11:0] PacketSize,
    output logic [15:0] MemAddress,
    output logic        MemReadEn,
    input  logic [31:0] MemData,
    output logic [31:0] TxData,
    output logic        TxCharIsK,
    output logic        Busy,
    output logic        Done,
    output logic        SizeError
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_TRAILER,
        ST_GAP
    } state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HDR,
        W_PAY,
        W_TRL
    } word_t;

    // TxData lags the state by two cycles, so the GAP state is one cycle
    // shorter than the idle run that appears on the link.
    localparam logic [3:0] GapLast = 4'(GapWords - 2);
    localparam logic [31:0] IdleWord = {24'h0, KIdle};

    state_t      state;
    state_t      state_nxt;
    word_t       word_sel;
    word_t       word_nxt;
    logic [11:0] remaining;
    logic [3:0]  gap_cnt;
    logic [15:0] addr;
    logic [31:0] hdr_dat;
    logic [31:0] checksum;
    logic        start_ok;
    logic        size_bad;

    assign start_ok   = Start && (PacketSize >= 12'd2);
    assign size_bad   = Start && (PacketSize < 12'd2);
    assign MemAddress = addr;
    assign MemReadEn  = (state == ST_PAYLOAD);
    assign Busy       = (state != ST_IDLE);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        word_nxt  = W_IDLE;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_nxt = ST_HEADER;
                end
            end
            ST_HEADER: begin
                word_nxt  = W_HDR;
                state_nxt = (remaining != 12'd0) ? ST_PAYLOAD : ST_TRAILER;
            end
            ST_PAYLOAD: begin
                word_nxt = W_PAY;
                if (remaining == 12'd1) begin
                    state_nxt = ST_TRAILER;
                end
            end
            ST_TRAILER: begin
                word_nxt  = W_TRL;
                state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt == GapLast) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request fields are captured once at acceptance; later input changes are ignored.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            addr      <= 16'h0000;
            remaining <= 12'd0;
            hdr_dat   <= 32'h0;
            gap_cnt   <= 4'd0;
        end else begin
            if ((state == ST_IDLE) && start_ok) begin
                addr      <= SourceAddress;
                remaining <= PacketSize - 12'd2;
                hdr_dat   <= {PacketSize, PacketDest, KStart};
            end else if (state == ST_PAYLOAD) begin
                addr      <= addr + 16'd1;
                remaining <= remaining - 12'd1;
            end
            gap_cnt <= (state == ST_GAP) ? gap_cnt + 4'd1 : 4'd0;
        end
    end

    // Second stage: MemData is valid one cycle after the read strobe, so the
    // word type is delayed one cycle to line up with it.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            word_sel  <= W_IDLE;
            TxData    <= IdleWord;
            TxCharIsK <= 1'b1;
            checksum  <= 32'h0;
            Done      <= 1'b0;
            SizeError <= 1'b0;
        end else begin
            word_sel  <= word_nxt;
            Done      <= (word_sel == W_TRL);
            SizeError <= (state == ST_IDLE) && size_bad;
            case (word_sel)
                W_HDR: begin
                    TxData    <= hdr_dat;
                    TxCharIsK <= 1'b1;
                    checksum  <= 32'h0;
                end
                W_PAY: begin
                    TxData    <= MemData;
                    TxCharIsK <= 1'b0;
                    checksum  <= checksum ^ MemData;
                end
                W_TRL: begin
                    TxData    <= checksum;
                    TxCharIsK <= 1'b0;
                end
                default: begin
                    TxData    <= IdleWord;
                    TxCharIsK <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_data_transmitter.sv
// Directed bench for stream_data_transmitter with a synchronous one-cycle-latency memory model.
module tb_stream_data_transmitter;

    localparam int unsigned GAP = 2;
    localparam logic [31:0] IDLE_W = 32'h000000BC;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic [15:0] SourceAddress;
    logic [11:0] PacketDest;
    logic [11:0] PacketSize;
    logic [15:0] MemAddress;
    logic        MemReadEn;
    logic [31:0] MemData;
    logic [31:0] TxData;
    logic        TxCharIsK;
    logic        Busy;
    logic        Done;
    logic        SizeError;

    logic [31:0] mem [0:65535];
    logic [15:0] rd_q [$];
    int tests = 0;
    int fails = 0;

    stream_data_transmitter #(
        .KStart  (8'h5C),
        .KIdle   (8'hBC),
        .GapWords(GAP)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Start        (Start),
        .SourceAddress(SourceAddress),
        .PacketDest   (PacketDest),
        .PacketSize   (PacketSize),
        .MemAddress   (MemAddress),
        .MemReadEn    (MemReadEn),
        .MemData      (MemData),
        .TxData       (TxData),
        .TxCharIsK    (TxCharIsK),
        .Busy         (Busy),
        .Done         (Done),
        .SizeError    (SizeError)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (MemReadEn) begin
            MemData <= mem[MemAddress];
            rd_q.push_back(MemAddress);
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // pre_ticks=3 issues a fresh Start; pre_ticks=1 continues a back-to-back packet already accepted.
    task automatic tx_packet(input logic [15:0] src, input logic [11:0] dest, input logic [11:0] size,
                             input logic [31:0] exp_hdr, input logic [31:0] exp_trl,
                             input int pre_ticks, input bit hold);
        logic [15:0] a;
        if (pre_ticks == 3) begin
            SourceAddress = src;
            PacketDest    = dest;
            PacketSize    = size;
            Start         = 1'b1;
        end
        for (int i = 0; i < pre_ticks; i++) begin
            tick();
            if (i == 0 && !hold) begin
                Start         = 1'b0;
                SourceAddress = 16'h5555;
                PacketDest    = 12'h777;
                PacketSize    = 12'h001;
            end
        end
        check("header", TxData, exp_hdr);
        check("header_k", {31'h0, TxCharIsK}, 32'd1);
        check("header_busy", {31'h0, Busy}, 32'd1);
        for (int n = 0; n < int'(size) - 2; n++) begin
            tick();
            a = src + 16'(n);
            check("payload", TxData, mem[a]);
            check("payload_k", {31'h0, TxCharIsK}, 32'd0);
            check("payload_done", {31'h0, Done}, 32'd0);
        end
        tick();
        check("trailer", TxData, exp_trl);
        check("trailer_k", {31'h0, TxCharIsK}, 32'd0);
        check("trailer_done", {31'h0, Done}, 32'd1);
        for (int g = 0; g < int'(GAP); g++) begin
            tick();
            check("gap_idle", TxData, IDLE_W);
            check("gap_k", {31'h0, TxCharIsK}, 32'd1);
            check("gap_done", {31'h0, Done}, 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        mem[16'h0010] = 32'd1;
        mem[16'h0011] = 32'd2;
        mem[16'h0012] = 32'd3;
        mem[16'h0013] = 32'd4;
        mem[16'h0020] = 32'hDEADBEEF;
        mem[16'hFFFE] = 32'h11110000;
        mem[16'hFFFF] = 32'h00FF00FF;
        mem[16'h0000] = 32'h12345678;

        Reset = 1'b0;
        Start = 1'b0;
        SourceAddress = 16'h0;
        PacketDest = 12'h0;
        PacketSize = 12'h0;
        tick();
        tick();
        check("rst_txdata", TxData, IDLE_W);
        check("rst_k", {31'h0, TxCharIsK}, 32'd1);
        check("rst_busy", {31'h0, Busy}, 32'd0);
        check("rst_memaddr", {16'h0, MemAddress}, 32'h0);
        check("rst_rden", {31'h0, MemReadEn}, 32'd0);
        check("rst_done", {31'h0, Done}, 32'd0);
        check("rst_sizeerr", {31'h0, SizeError}, 32'd0);
        Reset = 1'b1;
        tick();
        tick();

        // Basic six-word packet
        rd_q.delete();
        tx_packet(16'h0010, 12'h123, 12'd6, 32'h0061235C, 32'h00000004, 3, 1'b0);
        check("basic_reads", rd_q.size(), 32'd4);
        for (int i = 0; i < 4 && i < rd_q.size(); i++) check("basic_rd_addr", {16'h0, rd_q[i]}, 32'h10 + i);

        // Header + trailer only
        rd_q.delete();
        tx_packet(16'h0030, 12'h0AA, 12'd2, 32'h0020AA5C, 32'h00000000, 3, 1'b0);
        check("size2_no_reads", rd_q.size(), 32'd0);

        // Rejected sizes
        for (int s = 0; s < 2; s++) begin
            PacketSize = 12'(s);
            Start = 1'b1;
            tick();
            Start = 1'b0;
            check("sizeerr_pulse", {31'h0, SizeError}, 32'd1);
            check("sizeerr_busy", {31'h0, Busy}, 32'd0);
            tick();
            check("sizeerr_clear", {31'h0, SizeError}, 32'd0);
            tick();
            tick();
            check("sizeerr_idle", TxData, IDLE_W);
            check("sizeerr_busy2", {31'h0, Busy}, 32'd0);
        end

        // Address wrap
        rd_q.delete();
        tx_packet(16'hFFFE, 12'h456, 12'd5, 32'h0054565C, 32'h03DA5687, 3, 1'b0);
        check("wrap_reads", rd_q.size(), 32'd3);
        if (rd_q.size() == 3) begin
            check("wrap_rd0", {16'h0, rd_q[0]}, 32'h0000FFFE);
            check("wrap_rd1", {16'h0, rd_q[1]}, 32'h0000FFFF);
            check("wrap_rd2", {16'h0, rd_q[2]}, 32'h00000000);
        end

        // Start held high: second header follows exactly GAP idle words
        tx_packet(16'h0020, 12'hABC, 12'd3, 32'h003ABC5C, 32'hDEADBEEF, 3, 1'b1);
        tx_packet(16'h0020, 12'hABC, 12'd3, 32'h003ABC5C, 32'hDEADBEEF, 1, 1'b0);
        tick();
        check("b2b_stop_idle", TxData, IDLE_W);
        check("b2b_stop_busy", {31'h0, Busy}, 32'd0);

        // Reset during the second payload word
        SourceAddress = 16'h0010;
        PacketDest = 12'h123;
        PacketSize = 12'd6;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        tick();
        check("abort_hdr", TxData, 32'h0061235C);
        tick();
        check("abort_pay0", TxData, 32'd1);
        tick();
        check("abort_pay1", TxData, 32'd2);
        Reset = 1'b0;
        #1;
        check("abort_idle", TxData, IDLE_W);
        check("abort_k", {31'h0, TxCharIsK}, 32'd1);
        check("abort_busy", {31'h0, Busy}, 32'd0);
        check("abort_rden", {31'h0, MemReadEn}, 32'd0);
        check("abort_done", {31'h0, Done}, 32'd0);
        tick();
        tick();
        Reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_no_done", {31'h0, Done}, 32'd0);
            check("abort_stay_idle", TxData, IDLE_W);
        end
        tx_packet(16'h0010, 12'h123, 12'd6, 32'h0061235C, 32'h00000004, 3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stream_data_transmitter.md
STREAM_DATA_TRANSMITTER -- requirements
Module: stream_data_transmitter

Interface
REQ-001 SHALL have parameter KStart, default 8'h5C: K28.2 start-of-packet character placed in header byte [7:0].
REQ-002 SHALL have parameter KIdle, default 8'hBC: K28.5 idle character sent in byte [7:0] of every idle word.
REQ-003 SHALL have parameter GapWords, default 2: minimum idle words after each trailer, legal range 2..15.
REQ-004 SHALL have port Clock, input, 1 bit: single clock, all logic on its rising edge.
REQ-005 SHALL have port Reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port Start, input, 1 bit: single-cycle packet request, sampled only in IDLE.
REQ-007 SHALL have port SourceAddress, input, 16 bits: local memory address of first payload word.
REQ-008 SHALL have port PacketDest, input, 12 bits: destination address carried in header [19:8].
REQ-009 SHALL have port PacketSize, input, 12 bits: total words on link = header + payload + trailer.
REQ-010 SHALL have port MemAddress, output, 16 bits: payload read address.
REQ-011 SHALL have port MemReadEn, output, 1 bit: read strobe; MemData valid exactly 1 cycle after the strobe edge.
REQ-012 SHALL have port MemData, input, 32 bits: read data from the source memory.
REQ-013 SHALL have port TxData, output, 32 bits: registered link word.
REQ-014 SHALL have port TxCharIsK, output, 1 bit: registered; 1 when TxData[7:0] is a K character.
REQ-015 SHALL have port Busy, output, 1 bit: 1 in every state except IDLE.
REQ-016 SHALL have port Done, output, 1 bit: one-cycle pulse in the cycle the trailer is on TxData.
REQ-017 SHALL have port SizeError, output, 1 bit: one-cycle pulse when Start is rejected for PacketSize < 2.

Function
REQ-018 SHALL implement states IDLE, HEADER, PAYLOAD, TRAILER, GAP.
REQ-019 Transitions SHALL be: IDLE->HEADER on Start and PacketSize>=2; HEADER->PAYLOAD if PacketSize>2, else ->TRAILER; PAYLOAD->TRAILER after PacketSize-2 words; TRAILER->GAP; GAP->IDLE after GapWords idle words.
REQ-020 On Start acceptance, SourceAddress, PacketDest and PacketSize SHALL be latched; input changes mid-packet SHALL have no effect.
REQ-021 Start in any state other than IDLE SHALL be ignored; Start in IDLE with PacketSize<2 SHALL pulse SizeError the next cycle and stay IDLE.
REQ-022 Header word SHALL be {PacketSize, PacketDest, KStart} with TxCharIsK=1, on TxData 2 cycles after the edge sampling Start.
REQ-023 Payload words SHALL follow the header back-to-back, one per cycle, word n = memory[SourceAddress+n], n = 0..PacketSize-3, with TxCharIsK=0.
REQ-024 MemAddress SHALL increment by 1 per read, modulo 2^16 (0xFFFF wraps to 0x0000); MemReadEn SHALL issue exactly PacketSize-2 reads per packet.
REQ-025 Trailer word SHALL be the 32-bit XOR of all payload words (0x00000000 when there is no payload), with TxCharIsK=0.
REQ-026 In IDLE, GAP and after reset, TxData SHALL be {24'h0, KIdle} with TxCharIsK=1.
REQ-027 Total link words per packet SHALL equal the latched PacketSize; the packet SHALL be contiguous with no idle inserted.
REQ-028 A Start asserted in the first IDLE cycle after GAP SHALL be accepted (back-to-back packets separated by exactly GapWords idle words).

Reset
REQ-029 Reset low SHALL immediately force IDLE with TxData={24'h0,KIdle}, TxCharIsK=1, MemAddress=0, MemReadEn=0, Busy=0, Done=0, SizeError=0, checksum=0.
REQ-030 Reset asserted mid-packet SHALL abort the packet with no trailer and no Done; the first packet after release SHALL start from a fresh Start.

Verification
REQ-031 Start, SourceAddress=0x0010, PacketDest=0x123, PacketSize=6, memory[0x10..0x13]=1,2,3,4 -> 0x0061235C K=1, then 1,2,3,4 K=0, trailer 0x00000004, Done on trailer, then 2 idle words 0x000000BC.
REQ-032 PacketSize=2 -> header 0x0020xx5C, trailer 0x00000000, MemReadEn never asserted; PacketSize=1 -> SizeError pulse, TxData stays idle, Busy=0.
REQ-033 SourceAddress=0xFFFE, PacketSize=5 -> reads 0xFFFE, 0xFFFF, 0x0000.
REQ-034 Start held high through the whole packet -> second header exactly GapWords idle words after the first trailer; no header while Busy=1.
REQ-035 Reset low during the 2nd payload word -> idle word and Busy=0 immediately, no Done; next Start transmits the full packet correctly.
REQ-036 Loopback into the existing receiver (Reset inverted) -> PacketAddress, PacketLength and payload words/addresses match the transmitted values.
